// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read bypass).
package regfile_pkg;

   typedef enum logic {
      ST_INIT,
      ST_READY
   } state_t;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int NUM_RD_MAX = 4;

endpackage

// File: rtl/regfile_init_ctrl.sv
// Clear sequencer: walks every address after reset or on request,
// then raises ready.
module regfile_init_ctrl
   import regfile_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              init_req,
   output logic              ready,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              clr_we
);

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] cnt_q;
   logic [ADDR_W-1:0] cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
         ready   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready   <= (state_d == ST_READY);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_we  = 1'b0;
      unique case (state_q)
         ST_INIT: begin
            clr_we = 1'b1;
            cnt_d  = cnt_q + ADDR_W'(1);
            if (cnt_q == {ADDR_W{1'b1}})
               state_d = ST_READY;
         end
         ST_READY: begin
            if (init_req) begin
               state_d = ST_INIT;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, two prioritised
// writes, hardware clear. Define REGFILE_BYPASS_EN for write-to-read bypass.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     we0,
   input  logic [ADDR_W-1:0]        wa0,
   input  logic [DATA_W-1:0]        wd0,
   input  logic                     we1,
   input  logic [ADDR_W-1:0]        wa1,
   input  logic [DATA_W-1:0]        wd1,
   input  logic                     init_req,
   output logic                     ready,
   output logic                     wr_conflict
);

   localparam int DEPTH = 1 << ADDR_W;

   if (NUM_RD < 1 || NUM_RD > NUM_RD_MAX) begin : g_bad_num_rd
      $error("regfile_mp: NUM_RD out of range");
   end

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] clr_addr;
   logic              clr_we;
   logic              acc;
   logic              z0;
   logic              z1;
   logic              same;
   logic              w0_ok;
   logic              w1_ok;
   logic              conflict_d;

   regfile_init_ctrl #(
      .ADDR_W (ADDR_W)
   ) u_init (
      .clk      (clk),
      .rst_n    (rst_n),
      .init_req (init_req),
      .ready    (ready),
      .clr_addr (clr_addr),
      .clr_we   (clr_we)
   );

   // A write is accepted only in ST_READY and not on the re-init edge.
   assign acc   = ready & ~init_req;
   assign z0    = (ZERO_REG != 0) && (wa0 == '0);
   assign z1    = (ZERO_REG != 0) && (wa1 == '0);
   assign same  = (wa0 == wa1);
   assign w1_ok = acc & we1 & ~z1;
   assign w0_ok = acc & we0 & ~z0 & ~(w1_ok & same);

   assign conflict_d = acc & we0 & we1 & same & ~z0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wr_conflict <= 1'b0;
      else
         wr_conflict <= conflict_d;
   end

   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else begin
         if (w0_ok)
            mem[wa0] <= wd0;
         if (w1_ok)
            mem[wa1] <= wd1;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;

      assign a = rd_addr[k*ADDR_W +: ADDR_W];

      always_comb begin
         d = mem[a];
`ifdef REGFILE_BYPASS_EN
         if (w1_ok && wa1 == a)
            d = wd1;
         else if (w0_ok && wa0 == a)
            d = wd0;
`endif
         if (!ready)
            d = '0;
         else if (ZERO_REG != 0 && a == '0)
            d = '0;
      end

      assign rd_data[k*DATA_W +: DATA_W] = d;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: randomized and directed traffic
// checked against an array-level reference model.
module tb_regfile_mp;

   localparam int DEPTH = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  rd_addr = '0;
   logic [63:0] rd_data;
   logic        we0 = 1'b0;
   logic [4:0]  wa0 = '0;
   logic [31:0] wd0 = '0;
   logic        we1 = 1'b0;
   logic [4:0]  wa1 = '0;
   logic [31:0] wd1 = '0;
   logic        init_req = 1'b0;
   logic        ready;
   logic        wr_conflict;

   always #5 clk = ~clk;

   regfile_mp dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .we0         (we0),
      .wa0         (wa0),
      .wd0         (wd0),
      .we1         (we1),
      .wa1         (wa1),
      .wd1         (wd1),
      .init_req    (init_req),
      .ready       (ready),
      .wr_conflict (wr_conflict)
   );

   typedef struct {
      logic        rdy;
      logic        conf;
      logic [31:0] r0;
      logic [31:0] r1;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   bit   done = 0;

   logic [31:0] mdl [DEPTH];
   int          clr_left = DEPTH;
   bit          m_conf = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_rd(logic [4:0] a);
      if (clr_left != 0 || a == 0)
         return 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (!init_req) begin
         if (we1 && wa1 == a)
            return wd1;
         if (we0 && wa0 == a)
            return wd0;
      end
`endif
      return mdl[a];
   endfunction

   task automatic zero_mdl();
      for (int i = 0; i < DEPTH; i++)
         mdl[i] = 32'h0;
   endtask

   // One clock: retire the edge into the model, drive new inputs,
   // queue what the outputs must show for this cycle.
   task automatic step(bit r, bit i_we0, logic [4:0] i_wa0,
                       logic [31:0] i_wd0, bit i_we1, logic [4:0] i_wa1,
                       logic [31:0] i_wd1, bit i_init,
                       logic [4:0] a0, logic [4:0] a1);
      exp_t e;
      @(posedge clk);
      #1;
      if (rst_n) begin
         if (clr_left != 0) begin
            clr_left--;
            m_conf = 0;
         end else begin
            m_conf = we0 && we1 && wa0 == wa1 && wa0 != 0 && !init_req;
            if (init_req) begin
               clr_left = DEPTH;
               zero_mdl();
            end else begin
               if (we0 && wa0 != 0) mdl[wa0] = wd0;
               if (we1 && wa1 != 0) mdl[wa1] = wd1;
            end
         end
      end
      rst_n    = r;
      we0      = i_we0;
      wa0      = i_wa0;
      wd0      = i_wd0;
      we1      = i_we1;
      wa1      = i_wa1;
      wd1      = i_wd1;
      init_req = i_init;
      rd_addr  = {a1, a0};
      if (!r) begin
         clr_left = DEPTH;
         m_conf   = 0;
         zero_mdl();
      end
      e.rdy  = (clr_left == 0);
      e.conf = m_conf;
      e.r0   = exp_rd(a0);
      e.r1   = exp_rd(a1);
      q.push_back(e);
   endtask

   task automatic idle(int n, logic [4:0] a0, logic [4:0] a1);
      for (int i = 0; i < n; i++)
         step(1, 0, 0, 0, 0, 0, 0, 0, a0, a1);
   endtask

   task automatic sweep();
      for (int i = 0; i < DEPTH; i++)
         step(1, 0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("ready", {31'b0, ready}, {31'b0, e.rdy});
            chk("wr_conflict", {31'b0, wr_conflict}, {31'b0, e.conf});
            chk("rd_data0", rd_data[31:0], e.r0);
            chk("rd_data1", rd_data[63:32], e.r1);
         end
      end
   end

   initial begin : stim
      bit          r;
      bit          i0;
      bit          i1;
      bit          ini;
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic [4:0]  b0;
      logic [4:0]  b1;
      zero_mdl();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // clear after reset release, reading while it runs
      for (int i = 0; i < 36; i++)
         step(1, 0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
      sweep();
      // single writes on each port
      step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5, 7);
      step(1, 0, 0, 0, 1, 7, 32'h12345678, 0, 5, 7);
      idle(1, 5, 7);
      step(1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 5);
      idle(1, 0, 7);
      // collision, then back-to-back collisions
      step(1, 1, 9, 32'hAAAA0000, 1, 9, 32'h5555FFFF, 0, 9, 5);
      idle(2, 9, 7);
      step(1, 1, 10, 32'h1, 1, 10, 32'h2, 0, 10, 11);
      step(1, 1, 11, 32'h3, 1, 11, 32'h4, 0, 10, 11);
      step(1, 1, 0, 32'h5, 1, 0, 32'h6, 0, 10, 11);
      idle(2, 10, 11);
      // same-cycle visibility on a write
      step(1, 1, 3, 32'hCAFE, 0, 0, 0, 0, 3, 3);
      idle(1, 3, 9);
      // fill, re-init with writes during the window
      for (int i = 1; i < DEPTH; i++)
         step(1, 1, 5'(i), 32'h100 + i, 0, 0, 0, 0, 5'(i), 5'(i - 1));
      sweep();
      step(1, 1, 4, 32'hBAD0, 1, 6, 32'hBAD1, 1, 4, 6);
      for (int i = 0; i < 33; i++)
         step(1, 1, 5'(i), $urandom, 1, 5'(31 - i), $urandom,
              1'($urandom_range(0, 1)), 5'(i), 5'(31 - i));
      sweep();
      // reset in the middle of a clear
      step(1, 0, 0, 0, 0, 0, 0, 1, 1, 2);
      idle(9, 1, 2);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
      idle(34, 1, 2);
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         r   = ($urandom_range(0, 299) != 0);
         ini = ($urandom_range(0, 79) == 0);
         i0  = 1'($urandom_range(0, 1));
         i1  = 1'($urandom_range(0, 1));
         a0  = 5'($urandom_range(0, 31));
         a1  = ($urandom_range(0, 2) == 0) ? a0 : 5'($urandom_range(0, 31));
         b0  = ($urandom_range(0, 1) == 0) ? a0 : 5'($urandom_range(0, 31));
         b1  = ($urandom_range(0, 1) == 0) ? a1 : 5'($urandom_range(0, 31));
         step(r, i0, a0, $urandom, i1, a1, $urandom, ini, b0, b1);
      end
      idle(2, 0, 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      #1;
      chk("drain", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
